// File: rtl/timer_dev_pkg.sv
// Shared definitions for the countdown timer peripheral: register offsets,
// CTRL bit positions, mode encodings and the sequencer state type.
package timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_W       = 4;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_dev_if.sv
// Bridge-side bus of the timer: the bridge (master) drives address, strobe and
// write data; the timer (slave) answers with read data and its interrupt line.
interface timer_dev_if;
    logic [31:0] addr;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    modport master (output addr, output WE, output WD, input RD, input IRQ);
    modport slave  (input addr, input WE, input WD, output RD, output IRQ);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, a four-state
// load/count/interrupt sequencer and a combinational read mux.
module timer_dev
    import timer_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter bit RELOAD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    timer_dev_if.slave  bus
);

    logic [CTRL_W-1:0] ctrl_reg,     ctrl_next;
    logic [CNT_W-1:0]  preset_reg,   preset_next;
    logic [CNT_W-1:0]  count_reg,    count_next;
    logic              irq_flag_reg, irq_flag_next;
    state_t            state_reg,    state_next;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        reload_mode;
    logic        irq_set;
    logic [31:0] rd_val;
    logic        unused_bus;

    assign wr_ctrl     = bus.WE && (bus.addr[3:2] == REG_CTRL);
    assign wr_preset   = bus.WE && (bus.addr[3:2] == REG_PRESET);
    assign reload_mode = RELOAD_EN && (ctrl_reg[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
    assign unused_bus  = ^{bus.addr[31:4], bus.addr[1:0], bus.WD[31:CTRL_W]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_reg     <= '0;
            preset_reg   <= '0;
            count_reg    <= '0;
            irq_flag_reg <= 1'b0;
            state_reg    <= IDLE;
        end else begin
            ctrl_reg     <= ctrl_next;
            preset_reg   <= preset_next;
            count_reg    <= count_next;
            irq_flag_reg <= irq_flag_next;
            state_reg    <= state_next;
        end
    end

    always_comb begin
        ctrl_next     = ctrl_reg;
        preset_next   = preset_reg;
        count_next    = count_reg;
        irq_flag_next = irq_flag_reg;
        state_next    = state_reg;
        irq_set       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (ctrl_reg[CTRL_EN]) state_next = LOAD;
            end
            LOAD: begin
                count_next = preset_reg;
                state_next = CNT;
            end
            CNT: begin
                if (!ctrl_reg[CTRL_EN]) begin
                    state_next = IDLE;
                end else if (count_reg > CNT_W'(1)) begin
                    count_next = count_reg - CNT_W'(1);
                end else begin
                    // Terminal step also covers PRESET=0, so COUNT never wraps
                    count_next = '0;
                    irq_set    = 1'b1;
                    state_next = INT;
                end
            end
            INT: begin
                if (reload_mode) begin
                    irq_flag_next = 1'b0;
                    state_next    = LOAD;
                end else begin
                    ctrl_next[CTRL_EN] = 1'b0;
                    state_next         = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Bus writes are applied last so a CPU write to CTRL overrides the
        // one-shot EN clear in the same cycle.
        if (wr_ctrl)   ctrl_next   = bus.WD[CTRL_W-1:0];
        if (wr_preset) preset_next = bus.WD[CNT_W-1:0];

        if (irq_set)                     irq_flag_next = 1'b1;
        else if (wr_ctrl || wr_preset)   irq_flag_next = 1'b0;
    end

    always_comb begin
        rd_val = '0;
        case (bus.addr[3:2])
            REG_CTRL:   rd_val[CTRL_W-1:0] = ctrl_reg;
            REG_PRESET: rd_val[CNT_W-1:0]  = preset_reg;
            REG_COUNT:  rd_val[CNT_W-1:0]  = count_reg;
            default:    rd_val             = '0;
        endcase
    end

    assign bus.RD  = rd_val;
    assign bus.IRQ = irq_flag_reg & ctrl_reg[CTRL_IM];

endmodule
